// File: rtl/uart_cmd_wrapper.sv
// Knight-side serial link endpoint: UART RX assembling 16-bit commands (high byte first)
// plus an independent UART TX for 8-bit responses.
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  typedef enum logic {RX_IDLE = 1'b0, RX_RECV = 1'b1} rx_state_t;
  typedef enum logic {ASM_HIGH = 1'b0, ASM_LOW = 1'b1} asm_state_t;
  typedef enum logic {TX_IDLE = 1'b0, TX_XMIT = 1'b1} tx_state_t;

  // [1] is the synchronized line, [2] its previous value for edge detection
  logic [2:0]   rx_sync_q, rx_sync_d;
  rx_state_t    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_baud_q, rx_baud_d;
  logic [3:0]   rx_bit_q, rx_bit_d;
  logic [7:0]   rx_shift_q, rx_shift_d;
  asm_state_t   asm_state_q, asm_state_d;
  logic [15:0]  cmd_q, cmd_d;
  logic         cmd_rdy_q, cmd_rdy_d;
  tx_state_t    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]   tx_bit_q, tx_bit_d;
  logic [9:0]   tx_shift_q, tx_shift_d;
  logic         tx_done_q, tx_done_d;

  logic rx_line, rx_fall, rx_start, rx_valid;

  assign rx_line = rx_sync_q[1];
  assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];

  always_comb begin
    rx_sync_d  = {rx_sync_q[1:0], RX};
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_start   = 1'b0;
    rx_valid   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_RECV;
          rx_bit_d   = 4'd0;
          rx_baud_d  = BAUD_HALF;
          rx_start   = 1'b1;
        end
      end
      RX_RECV: begin
        if (rx_baud_q == BAUD_ONE) begin
          rx_baud_d = BAUD_FULL;
          rx_bit_d  = rx_bit_q + 4'd1;
          if (rx_bit_q == 4'd9) begin
            rx_state_d = RX_IDLE;
            rx_bit_d   = 4'd0;
            rx_valid   = rx_line;
          end else if (rx_bit_q != 4'd0) begin
            rx_shift_d = {rx_line, rx_shift_q[7:1]};
          end
        end else begin
          rx_baud_d = rx_baud_q - BAUD_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Clear precedes set so a byte completing alongside clr_cmd_rdy still raises cmd_rdy
  always_comb begin
    asm_state_d = asm_state_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    if (clr_cmd_rdy || (rx_start && asm_state_q == ASM_HIGH))
      cmd_rdy_d = 1'b0;
    if (rx_valid) begin
      if (asm_state_q == ASM_HIGH) begin
        cmd_d[15:8] = rx_shift_q;
        asm_state_d = ASM_LOW;
      end else begin
        cmd_d[7:0]  = rx_shift_q;
        cmd_rdy_d   = 1'b1;
        asm_state_d = ASM_HIGH;
      end
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = tx_done_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (trmt) begin
          tx_shift_d = {1'b1, resp, 1'b0};
          tx_done_d  = 1'b0;
          tx_baud_d  = BAUD_FULL;
          tx_bit_d   = 4'd0;
          tx_state_d = TX_XMIT;
        end
      end
      TX_XMIT: begin
        if (tx_baud_q == BAUD_ONE) begin
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          tx_baud_d  = BAUD_FULL;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d   = 4'd0;
            tx_state_d = TX_IDLE;
            tx_done_d  = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_baud_d = tx_baud_q - BAUD_ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q   <= 3'b111;
      rx_state_q  <= RX_IDLE;
      rx_baud_q   <= '0;
      rx_bit_q    <= 4'd0;
      rx_shift_q  <= 8'h00;
      asm_state_q <= ASM_HIGH;
      cmd_q       <= 16'h0000;
      cmd_rdy_q   <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_baud_q   <= '0;
      tx_bit_q    <= 4'd0;
      tx_shift_q  <= 10'h3FF;
      tx_done_q   <= 1'b0;
    end else begin
      rx_sync_q   <= rx_sync_d;
      rx_state_q  <= rx_state_d;
      rx_baud_q   <= rx_baud_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      asm_state_q <= asm_state_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      tx_state_q  <= tx_state_d;
      tx_baud_q   <= tx_baud_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign TX      = tx_shift_q[0];
  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Bench for uart_cmd_wrapper: a RemoteComm-like serial driver/decoder and a command-value model.
module tb_uart_cmd_wrapper;
  localparam int BAUD = 16;

  logic clk = 1'b0;
  logic rst_n, RX, TX, cmd_rdy, clr_cmd_rdy, trmt, tx_done;
  logic [15:0] cmd;
  logic [7:0] resp;
  logic [15:0] exp_cmd;
  int n_checks = 0;
  int n_fail = 0;

  uart_cmd_wrapper #(.BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drives one serial frame; reports when cmd_rdy first rises in the stop bit and first falls in the start bit
  task automatic send_byte(input logic [7:0] b, input logic stop, output int rdy_at, output int drop_at);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    rdy_at = -1;
    drop_at = -1;
    for (int i = 0; i < 10; i++) begin
      RX = frame[i];
      for (int k = 0; k < BAUD; k++) begin
        @(negedge clk);
        if (i == 9 && rdy_at < 0 && cmd_rdy === 1'b1) rdy_at = k;
        if (i == 0 && drop_at < 0 && cmd_rdy === 1'b0) drop_at = k;
      end
    end
    RX = 1'b1;
  endtask

  // Full command with cmd_rdy already clear; clears cmd_rdy at the end
  task automatic send_cmd(input logic [15:0] c);
    int r, d;
    send_byte(c[15:8], 1'b1, r, d);
    exp_cmd[15:8] = c[15:8];
    n_checks++;
    if (cmd !== exp_cmd || cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL high_byte: cmd=%h rdy=%b, expected cmd=%h rdy=0", cmd, cmd_rdy, exp_cmd);
    end
    send_byte(c[7:0], 1'b1, r, d);
    exp_cmd[7:0] = c[7:0];
    n_checks++;
    if (r < BAUD / 2 || r > BAUD / 2 + 4) begin
      n_fail++;
      $display("FAIL rdy_latency: rose at stop-bit cycle %0d, expected %0d..%0d", r, BAUD / 2, BAUD / 2 + 4);
    end
    n_checks++;
    if (cmd !== exp_cmd || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_value: cmd=%h rdy=%b, expected cmd=%h rdy=1", cmd, cmd_rdy, exp_cmd);
    end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    n_checks++;
    if (cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_cmd_rdy: rdy=%b, expected 0", cmd_rdy);
    end
    $display("rx cmd %h -> cmd=%h", c, cmd);
  endtask

  // Sends resp r and decodes TX; optional second trmt mid-frame with a different resp
  task automatic tx_frame(input logic [7:0] r, input logic retrigger);
    logic txs [0:10*BAUD-1];
    logic [9:0] expf, got;
    logic done_mid;
    expf = {1'b1, r, 1'b0};
    resp = r;
    trmt = 1'b1;
    @(negedge clk);
    resp = ~r;
    done_mid = 1'b0;
    for (int idx = 0; idx < 10 * BAUD; idx++) begin
      txs[idx] = TX;
      if (idx == 10 * BAUD - 1 || idx == 0) done_mid = done_mid | tx_done;
      trmt = (retrigger && idx == 4 * BAUD + 3);
      if (trmt) resp = 8'h5A;
      @(negedge clk);
    end
    trmt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      got[i] = txs[i * BAUD + BAUD / 2];
      n_checks++;
      if (got[i] !== expf[i]) begin
        n_fail++;
        $display("FAIL tx_bit%0d: TX=%b, expected %b (resp %h)", i, got[i], expf[i], r);
      end
    end
    n_checks++;
    if (got[8:1] !== r) begin
      n_fail++;
      $display("FAIL tx_byte: decoded %h, expected %h", got[8:1], r);
    end
    n_checks++;
    if (done_mid !== 1'b0 || tx_done !== 1'b1 || TX !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_done: during=%b after=%b TX=%b, expected 0/1/1", done_mid, tx_done, TX);
    end
    $display("tx resp %h decoded %h retrigger=%b", r, got[8:1], retrigger);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; RX = 1'b1; trmt = 1'b0; clr_cmd_rdy = 1'b0; resp = 8'h00;
    exp_cmd = 16'h0000;
    idle(3);
    n_checks++;
    if (TX !== 1'b1 || cmd !== 16'h0000 || cmd_rdy !== 1'b0 || tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: TX=%b cmd=%h rdy=%b done=%b, expected 1/0000/0/0", TX, cmd, cmd_rdy, tx_done);
    end
    rst_n = 1'b1;
    idle(4);
    n_checks++;
    if (TX !== 1'b1 || cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: TX=%b rdy=%b, expected 1/0", TX, cmd_rdy);
    end
    $display("reset done");
  endtask

  task automatic test_no_clear;
    int r, d;
    send_byte(8'h3F, 1'b1, r, d);
    send_byte(8'hF1, 1'b1, r, d);
    exp_cmd = 16'h3FF1;
    idle(3);
    send_byte(8'h3B, 1'b1, r, d);
    n_checks++;
    if (d < 1 || d > 4) begin
      n_fail++;
      $display("FAIL rdy_drop: fell at start-bit cycle %0d, expected 1..4", d);
    end
    exp_cmd[15:8] = 8'h3B;
    n_checks++;
    if (cmd !== exp_cmd || cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL second_high: cmd=%h rdy=%b, expected %h/0", cmd, cmd_rdy, exp_cmd);
    end
    send_byte(8'hF2, 1'b1, r, d);
    exp_cmd[7:0] = 8'hF2;
    n_checks++;
    if (cmd !== exp_cmd || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL second_cmd: cmd=%h rdy=%b, expected %h/1", cmd, cmd_rdy, exp_cmd);
    end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    $display("rx cmd 3ff1 then 3bf2 without clear -> cmd=%h", cmd);
  endtask

  task automatic test_random_cmds;
    for (int n = 0; n < 6; n++) begin
      send_cmd(16'($urandom));
      idle($urandom_range(0, 20));
    end
  endtask

  task automatic test_framing;
    int r, d;
    send_byte(8'h77, 1'b0, r, d);
    idle(2 * BAUD);
    n_checks++;
    if (cmd !== exp_cmd || cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL framing_drop: cmd=%h rdy=%b, expected %h/0", cmd, cmd_rdy, exp_cmd);
    end
    send_cmd(16'h3001);
  endtask

  task automatic test_reset_midbyte;
    logic [9:0] frame;
    int r, d;
    send_byte(8'h30, 1'b1, r, d);
    resp = 8'h00;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    frame = {1'b1, 8'h02, 1'b0};
    for (int i = 0; i < 4; i++) begin
      RX = frame[i];
      idle(BAUD);
    end
    n_checks++;
    if (TX !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_active: TX=%b, expected 0 mid-frame", TX);
    end
    rst_n = 1'b0;
    RX = 1'b1;
    exp_cmd = 16'h0000;
    #1;
    n_checks++;
    if (TX !== 1'b1 || cmd !== 16'h0000 || cmd_rdy !== 1'b0 || tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midbyte_reset: TX=%b cmd=%h rdy=%b done=%b", TX, cmd, cmd_rdy, tx_done);
    end
    @(negedge clk);
    n_checks++;
    if (TX !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tx_hold: TX=%b, expected 1", TX);
    end
    rst_n = 1'b1;
    idle(12 * BAUD);
    n_checks++;
    if (cmd_rdy !== 1'b0 || TX !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset_idle: rdy=%b TX=%b, expected 0/1", cmd_rdy, TX);
    end
    send_cmd(16'h3002);
  endtask

  task automatic test_full_duplex;
    fork
      send_cmd(16'h3001);
      tx_frame(8'hA5, 1'b0);
    join
    idle(5);
    fork
      send_cmd(16'($urandom));
      tx_frame(8'($urandom), 1'b1);
    join
  endtask

  initial begin
    test_reset;
    send_cmd(16'h0000);
    test_no_clear;
    test_random_cmds;
    tx_frame(8'hA5, 1'b1);
    for (int n = 0; n < 3; n++) tx_frame(8'($urandom), 1'($urandom));
    test_framing;
    test_reset_midbyte;
    test_full_duplex;
    idle(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
